// File: rtl/image_binarize_packer_if.sv
// Frame-buffer read port and packed-byte output stream of image_binarize_packer.
// The packer drives through the master modport; the frame buffer and host link use the slave one.
interface image_binarize_packer_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int BIT_DEPTH  = 12
);
    logic                  readEnable;
    logic [ADDR_WIDTH-1:0] readAddr;
    logic [BIT_DEPTH-1:0]  readData;
    logic                  outValid;
    logic [7:0]            outData;
    logic                  outLast;
    logic                  outReady;

    modport master (
        output readEnable, readAddr, outValid, outData, outLast,
        input  readData, outReady
    );

    modport slave (
        input  readEnable, readAddr, outValid, outData, outLast,
        output readData, outReady
    );
endinterface

// File: rtl/image_binarize_packer.sv
// Reads a captured frame, thresholds each pixel to one bit and streams the bits
// out packed eight per byte, lowest address in bit 0.
module image_binarize_packer #(
    parameter int NUM_PIXELS = 4800,
    parameter int ADDR_WIDTH = $clog2(NUM_PIXELS),
    parameter int BIT_DEPTH  = 12
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [BIT_DEPTH-1:0]    threshold,
    output logic                    busy,
    output logic                    done,
    image_binarize_packer_if.master bus
);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {IDLE, READ, CAPTURE, EMIT} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            bitCnt;
    logic [7:0]            packReg;
    logic [BIT_DEPTH-1:0]  thrReg;
    logic [7:0]            packNext;
    logic                  pixelBit;
    logic                  atLast;

    // Byte as it will look once the pixel returned this cycle is folded in.
    always_comb begin
        pixelBit         = (bus.readData >= thrReg);
        packNext         = packReg;
        packNext[bitCnt] = pixelBit;
    end

    assign atLast = (addr == LAST_ADDR);

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            bus.readEnable <= 1'b0;
            bus.readAddr   <= '0;
            bus.outValid   <= 1'b0;
            bus.outData    <= '0;
            bus.outLast    <= 1'b0;
            addr           <= '0;
            bitCnt         <= '0;
            packReg        <= '0;
            thrReg         <= '0;
        end else begin
            done           <= 1'b0;
            bus.readEnable <= 1'b0;
            if (state != IDLE && abort) begin
                state        <= IDLE;
                busy         <= 1'b0;
                bus.outValid <= 1'b0;
                bus.outLast  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            thrReg         <= threshold;
                            addr           <= '0;
                            bitCnt         <= '0;
                            packReg        <= '0;
                            bus.readEnable <= 1'b1;
                            bus.readAddr   <= '0;
                            busy           <= 1'b1;
                            state          <= READ;
                        end
                    end
                    READ: begin
                        state <= CAPTURE;
                    end
                    CAPTURE: begin
                        packReg <= packNext;
                        if (bitCnt == 3'd7 || atLast) begin
                            bus.outValid <= 1'b1;
                            bus.outData  <= packNext;
                            bus.outLast  <= atLast;
                            state        <= EMIT;
                        end else begin
                            addr           <= addr + 1'b1;
                            bitCnt         <= bitCnt + 3'd1;
                            bus.readEnable <= 1'b1;
                            bus.readAddr   <= addr + 1'b1;
                            state          <= READ;
                        end
                    end
                    EMIT: begin
                        // Output stays frozen until the host link takes the byte.
                        if (bus.outReady) begin
                            bus.outValid <= 1'b0;
                            bus.outLast  <= 1'b0;
                            if (bus.outLast) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                addr           <= addr + 1'b1;
                                bitCnt         <= '0;
                                packReg        <= '0;
                                bus.readEnable <= 1'b1;
                                bus.readAddr   <= addr + 1'b1;
                                state          <= READ;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule
